// File: rtl/cordic_mm_pipe_if.sv
// ---------------------------------------------------------------------------
// cordic_mm_pipe_if
// Stream interface of the multi-mode CORDIC pipeline. It bundles the input
// sample channel and the output result channel. Each channel is a
// valid/ready pair with its data.
//
// Signals (named from the CORDIC block's point of view)
//   tvalid_data_i  input sample valid
//   tready_data_i  block can accept an input sample this cycle
//   mode_i         0 = rotation, 1 = vectoring
//   x_i, y_i       input vector, signed DATA_WIDTH
//   z_i            input phase, 2^32 = full turn
//   tvalid_data_o  result valid
//   tready_data_o  downstream accepts the result
//   mode_o         mode carried with the result
//   x_o, y_o       result vector, saturated, signed DATA_WIDTH
//   z_o            result phase
//
// Modports
//   slave  : the CORDIC block itself
//   master : the environment driving samples and consuming results
// ---------------------------------------------------------------------------
interface cordic_mm_pipe_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         tvalid_data_i;
    logic                         tready_data_i;
    logic                         mode_i;
    logic signed [DATA_WIDTH-1:0] x_i;
    logic signed [DATA_WIDTH-1:0] y_i;
    logic [31:0]                  z_i;
    logic                         tvalid_data_o;
    logic                         tready_data_o;
    logic                         mode_o;
    logic signed [DATA_WIDTH-1:0] x_o;
    logic signed [DATA_WIDTH-1:0] y_o;
    logic [31:0]                  z_o;

    modport slave (
        input  tvalid_data_i, mode_i, x_i, y_i, z_i, tready_data_o,
        output tready_data_i, tvalid_data_o, mode_o, x_o, y_o, z_o
    );

    modport master (
        output tvalid_data_i, mode_i, x_i, y_i, z_i, tready_data_o,
        input  tready_data_i, tvalid_data_o, mode_o, x_o, y_o, z_o
    );
endinterface

// File: rtl/cordic_mm_pipe.sv
// ---------------------------------------------------------------------------
// cordic_mm_pipe
// Pipelined multi-mode CORDIC engine with a valid/ready stream on both sides.
// Each transaction selects its own mode:
//   rotation  (mode 0): rotate (x,y) by angle z, and drive z toward 0
//   vectoring (mode 1): drive y toward 0, and accumulate the vector angle into z
// Pipeline: a quadrant pre-rotation stage, ITERATION_CNT micro-rotation
// stages, then a saturating output register. The whole pipe advances only
// when the output register is empty or being accepted. It produces one
// result per clock when not stalled.
//
// Ports
//   aclk     clock
//   aresetn  asynchronous active-low reset
//   bus      cordic_mm_pipe_if.slave (input sample channel, output result channel)
//
// Parameters
//   DATA_WIDTH     x/y width, signed
//   ITERATION_CNT  number of micro-rotation stages (1..31)
//   GUARD_BITS     extra MSBs on the internal x/y path that absorb the CORDIC gain
//
// Optional feature (macro CORDIC_GAIN_COMP_EN)
//   When defined, a registered stage before saturation scales x/y by 1/K.
//   This adds one cycle of latency.
// ---------------------------------------------------------------------------
module cordic_mm_pipe #(
    parameter int DATA_WIDTH    = 16,
    parameter int ITERATION_CNT = 12,
    parameter int GUARD_BITS    = 2
) (
    input  logic            aclk,
    input  logic            aresetn,
    cordic_mm_pipe_if.slave bus
);
    localparam int  IW = DATA_WIDTH + GUARD_BITS;
    localparam int  N  = ITERATION_CNT;
    localparam real PI = 3.14159265358979323846;

    typedef logic signed [IW-1:0]         dp_t;
    typedef logic signed [DATA_WIDTH-1:0] dw_t;

    localparam dp_t SAT_MAX = dp_t'((longint'(1) <<< (DATA_WIDTH - 1)) - 1);
    localparam dp_t SAT_MIN = dp_t'(-(longint'(1) <<< (DATA_WIDTH - 1)));

    // Arctangent table entry: atan(2^-idx) as a fraction of a full turn, scaled to 2^32.
    function automatic logic [31:0] atanConst(input int idx);
        real r;
        r = $atan(1.0 / (2.0 ** idx)) / (2.0 * PI) * 4294967296.0;
        return 32'($rtoi(r + 0.5));
    endfunction

    // Clamp the wide internal value into the output range instead of letting it wrap.
    function automatic dw_t saturate(input dp_t v);
        if (v > SAT_MAX) begin
            return dw_t'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return dw_t'(SAT_MIN);
        end
        return dw_t'(v);
    endfunction

    // Global flow control: every register moves together, or none of them moves.
    logic advance;
    logic outValid_q;
    logic outMode_q;
    dw_t  outX_q;
    dw_t  outY_q;
    logic [31:0] outZ_q;

    assign advance           = !outValid_q || bus.tready_data_o;
    assign bus.tready_data_i = advance;
    assign bus.tvalid_data_o = outValid_q;
    assign bus.mode_o        = outMode_q;
    assign bus.x_o           = outX_q;
    assign bus.y_o           = outY_q;
    assign bus.z_o           = outZ_q;

    // Inputs are sign-extended into the guard-bit datapath first.
    // This lets negating the most-negative input stay representable.
    dp_t inX;
    dp_t inY;
    assign inX = dp_t'(bus.x_i);
    assign inY = dp_t'(bus.y_i);

    // Quadrant pre-rotation. It brings the problem into the +/-90 degree
    // range where the micro-rotations converge. Rotation mode folds the
    // angle by +/-90 degrees. Vectoring mode mirrors left-half-plane
    // vectors through the origin.
    dp_t         preX_d;
    dp_t         preY_d;
    logic [31:0] preZ_d;
    always_comb begin
        preX_d = inX;
        preY_d = inY;
        preZ_d = bus.z_i;
        if (bus.mode_i) begin
            if (inX[IW-1]) begin
                preX_d = -inX;
                preY_d = -inY;
                preZ_d = bus.z_i + 32'h8000_0000;
            end
        end else if (bus.z_i[31:30] == 2'b01) begin
            preX_d = -inY;
            preY_d = inX;
            preZ_d = bus.z_i - 32'h4000_0000;
        end else if (bus.z_i[31:30] == 2'b10) begin
            preX_d = inY;
            preY_d = -inX;
            preZ_d = bus.z_i + 32'h4000_0000;
        end
    end

    // Stage registers. Index 0 holds the pre-rotated sample.
    // Index k holds the sample after micro-rotation k-1.
    logic        vld_q  [0:N];
    logic        mode_q [0:N];
    dp_t         x_q    [0:N];
    dp_t         y_q    [0:N];
    logic [31:0] z_q    [0:N];
    dp_t         x_d    [1:N];
    dp_t         y_d    [1:N];
    logic [31:0] z_d    [1:N];

    // Micro-rotation i. dirPos selects the d = +1 direction.
    // That is z >= 0 in rotation mode, or y < 0 in vectoring mode.
    for (genvar i = 0; i < N; i++) begin : g_stage
        localparam logic [31:0] ATAN_I = atanConst(i);
        dp_t  xShift;
        dp_t  yShift;
        logic dirPos;
        assign xShift   = x_q[i] >>> i;
        assign yShift   = y_q[i] >>> i;
        assign dirPos   = mode_q[i] ? y_q[i][IW-1] : !z_q[i][31];
        assign x_d[i+1] = dirPos ? x_q[i] - yShift : x_q[i] + yShift;
        assign y_d[i+1] = dirPos ? y_q[i] + xShift : y_q[i] - xShift;
        assign z_d[i+1] = dirPos ? z_q[i] - ATAN_I : z_q[i] + ATAN_I;
    end

    // Pipeline shift. A bubble travels as vld_q = 0. Its data still moves,
    // but nothing downstream looks at it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k <= N; k++) begin
                vld_q[k]  <= 1'b0;
                mode_q[k] <= 1'b0;
                x_q[k]    <= '0;
                y_q[k]    <= '0;
                z_q[k]    <= '0;
            end
        end else if (advance) begin
            vld_q[0]  <= bus.tvalid_data_i;
            mode_q[0] <= bus.mode_i;
            x_q[0]    <= preX_d;
            y_q[0]    <= preY_d;
            z_q[0]    <= preZ_d;
            for (int k = 1; k <= N; k++) begin
                vld_q[k]  <= vld_q[k-1];
                mode_q[k] <= mode_q[k-1];
                x_q[k]    <= x_d[k];
                y_q[k]    <= y_d[k];
                z_q[k]    <= z_d[k];
            end
        end
    end

    logic        finValid;
    logic        finMode;
    dp_t         finX;
    dp_t         finY;
    logic [31:0] finZ;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int CW = DATA_WIDTH + 1;
    localparam int PW = IW + CW;

    // round(2^(DATA_WIDTH-1) / K), where K is the accumulated gain of all micro-rotations.
    function automatic logic signed [CW-1:0] compConst();
        real k;
        k = 1.0;
        for (int i = 0; i < N; i++) begin
            k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
        end
        return CW'($rtoi((2.0 ** (DATA_WIDTH - 1)) / k + 0.5));
    endfunction

    localparam logic signed [CW-1:0] COMP = compConst();

    logic signed [PW-1:0] prodX;
    logic signed [PW-1:0] prodY;
    logic                 compValid_q;
    logic                 compMode_q;
    dp_t                  compX_q;
    dp_t                  compY_q;
    logic [31:0]          compZ_q;

    assign prodX = x_q[N] * COMP;
    assign prodY = y_q[N] * COMP;

    // Gain compensation stage. The constant is a fixed-point fraction
    // with DATA_WIDTH-1 fractional bits, so the product is shifted back down.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            compValid_q <= 1'b0;
            compMode_q  <= 1'b0;
            compX_q     <= '0;
            compY_q     <= '0;
            compZ_q     <= '0;
        end else if (advance) begin
            compValid_q <= vld_q[N];
            compMode_q  <= mode_q[N];
            compX_q     <= dp_t'(prodX >>> (DATA_WIDTH - 1));
            compY_q     <= dp_t'(prodY >>> (DATA_WIDTH - 1));
            compZ_q     <= z_q[N];
        end
    end

    assign finValid = compValid_q;
    assign finMode  = compMode_q;
    assign finX     = compX_q;
    assign finY     = compY_q;
    assign finZ     = compZ_q;
`else
    assign finValid = vld_q[N];
    assign finMode  = mode_q[N];
    assign finX     = x_q[N];
    assign finY     = y_q[N];
    assign finZ     = z_q[N];
`endif

    // Output register. It holds its contents while the result is offered but not taken.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outValid_q <= 1'b0;
            outMode_q  <= 1'b0;
            outX_q     <= '0;
            outY_q     <= '0;
            outZ_q     <= '0;
        end else if (advance) begin
            outValid_q <= finValid;
            outMode_q  <= finMode;
            outX_q     <= saturate(finX);
            outY_q     <= saturate(finY);
            outZ_q     <= finZ;
        end
    end
endmodule

// File: tb/tb_cordic_mm_pipe.sv
// ---------------------------------------------------------------------------
// tb_cordic_mm_pipe
// Directed bench for cordic_mm_pipe (default build: no gain compensation).
// It covers reset values, rotation and vectoring results, quadrant
// pre-rotation, output saturation, backpressure ordering/holding, and
// reset while samples are in flight. Expected values are the ideal
// CORDIC results (input scaled by K ~= 1.6468), with an LSB tolerance
// for truncation.
// ---------------------------------------------------------------------------
module tb_cordic_mm_pipe;
    localparam int     DW      = 16;
    localparam int     ITERS   = 12;
    localparam int     LATENCY = ITERS + 2;
    // Truncating shifts bias every stage toward -inf. Along the 180 degree
    // path this accumulates to roughly 8 LSB on the near-zero axis.
    localparam longint XY_TOL  = 10;
    localparam longint BP_TOL  = 20;
    localparam longint Z_TOL   = 2097152;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    cordic_mm_pipe_if #(.DATA_WIDTH(DW)) bus ();

    cordic_mm_pipe #(
        .DATA_WIDTH   (DW),
        .ITERATION_CNT(ITERS),
        .GUARD_BITS   (2)
    ) dut (
        .aclk   (clk),
        .aresetn(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Exact comparison
    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Signed comparison with a tolerance
    task automatic checkNear(input string tag, input longint obs, input longint exp, input longint tol);
        longint diff;
        bit     inTol;
        diff  = (obs > exp) ? obs - exp : exp - obs;
        inTol = (diff <= tol);
        total++;
        assert (inTol === 1'b1) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // Phase comparison modulo 2^32
    task automatic checkPhase(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        longint diff;
        bit     inTol;
        diff  = longint'(int'(obs - exp));
        if (diff < 0) diff = -diff;
        inTol = (diff <= Z_TOL);
        total++;
        assert (inTol === 1'b1) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, exp, Z_TOL);
        end
    endtask

    // Offer one sample, then count cycles until the result appears (bounded)
    task automatic applyStimulus(input logic m, input logic signed [15:0] x, input logic signed [15:0] y,
                                 input logic [31:0] z, output int lat);
        bus.tvalid_data_i = 1'b1;
        bus.mode_i        = m;
        bus.x_i           = x;
        bus.y_i           = y;
        bus.z_i           = z;
        @(posedge clk);
        #1;
        bus.tvalid_data_i = 1'b0;
        lat = 1;
        while (bus.tvalid_data_o !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runDirected(input string tag, input logic m, input logic signed [15:0] x,
                               input logic signed [15:0] y, input logic [31:0] z,
                               input longint expX, input longint expY, input longint tol,
                               input logic [31:0] expZ);
        int lat;
        applyStimulus(m, x, y, z, lat);
        checkOutput({tag, ".latency"}, 96'(lat), 96'(LATENCY));
        checkOutput({tag, ".mode"}, 96'(bus.mode_o), 96'(m));
        checkNear({tag, ".x"}, longint'(bus.x_o), expX, tol);
        checkNear({tag, ".y"}, longint'(bus.y_o), expY, tol);
        checkPhase({tag, ".z"}, bus.z_o, expZ);
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [15:0] bpX(input int k);
        return 16'(500 + 900 * k);
    endfunction

    function automatic longint bpExp(input int k);
        return ((500 + 900 * longint'(k)) * 16468 + 5000) / 10000;
    endfunction

    initial begin
        int          sent;
        int          recv;
        int          cyc;
        logic        stalledPrev;
        logic [95:0] held;
        bit          sawValid;

        bus.tvalid_data_i = 1'b0;
        bus.mode_i        = 1'b0;
        bus.x_i           = '0;
        bus.y_i           = '0;
        bus.z_i           = '0;
        bus.tready_data_o = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.tvalid", 96'(bus.tvalid_data_o), 96'(0));
        checkOutput("reset.data", {bus.mode_o, bus.x_o, bus.y_o, bus.z_o}, 96'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset.tready", 96'(bus.tready_data_i), 96'(1));

        // Rotation by 45 degrees: 10000 * K / sqrt(2) ~= 11645 on both axes
        runDirected("rot45", 1'b0, 16'sd10000, 16'sd0, 32'h2000_0000, 11645, 11645, XY_TOL, 32'd0);
        // Vectoring (3000,4000): |v| * K ~= 8234, angle 53.13 deg
        runDirected("vec", 1'b1, 16'sd3000, 16'sd4000, 32'd0, 8234, 0, XY_TOL, 32'd633866735);
        // Rotation by 180 degrees uses the -90 pre-rotation
        runDirected("rot180", 1'b0, 16'sd10000, 16'sd0, 32'h8000_0000, -16468, 0, XY_TOL, 32'd0);
        // Vectoring in the third quadrant: the angle is offset by half a turn
        runDirected("vecQ3", 1'b1, -16'sd3000, -16'sd4000, 32'd0, 8234, 0, XY_TOL, 32'd2781350383);
        // Saturation: 32767 * K overflows the output range and must clamp positive
        runDirected("sat", 1'b0, 16'sd32767, 16'sd32767, 32'd0, 32767, 32767, 0, 32'd0);

        // Backpressure: 20 back-to-back samples, random output ready
        sent        = 0;
        recv        = 0;
        cyc         = 0;
        stalledPrev = 1'b0;
        held        = '0;
        bus.tvalid_data_i = 1'b1;
        bus.mode_i        = 1'b0;
        bus.x_i           = bpX(0);
        bus.y_i           = '0;
        bus.z_i           = '0;
        bus.tready_data_o = ($urandom_range(0, 3) != 0);
        while (recv < 20 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            checkOutput("bp.tready", 96'(bus.tready_data_i),
                        96'(!bus.tvalid_data_o || bus.tready_data_o));
            if (stalledPrev) begin
                checkOutput("bp.hold", {bus.tvalid_data_o, bus.mode_o, bus.x_o, bus.y_o, bus.z_o}, held);
            end
            if (bus.tvalid_data_o && bus.tready_data_o) begin
                checkOutput("bp.mode", 96'(bus.mode_o), 96'(0));
                checkNear("bp.x", longint'(bus.x_o), bpExp(recv), BP_TOL);
                checkNear("bp.y", longint'(bus.y_o), 0, BP_TOL);
                recv++;
            end
            stalledPrev = bus.tvalid_data_o && !bus.tready_data_o;
            held        = {bus.tvalid_data_o, bus.mode_o, bus.x_o, bus.y_o, bus.z_o};
            if (bus.tvalid_data_i && bus.tready_data_i) sent++;
            @(posedge clk);
            #1;
            bus.tvalid_data_i = (sent < 20);
            bus.x_i           = bpX(sent);
            bus.tready_data_o = ($urandom_range(0, 3) != 0);
        end
        checkOutput("bp.count", 96'(recv), 96'(20));
        bus.tvalid_data_i = 1'b0;
        bus.tready_data_o = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Reset while the pipe is full of vectoring samples
        bus.mode_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.tvalid_data_i = 1'b1;
            bus.x_i           = 16'(1000 + 100 * k);
            bus.y_i           = 16'sd200;
            bus.z_i           = '0;
            @(posedge clk);
            #1;
        end
        bus.tvalid_data_i = 1'b0;
        checkOutput("rst.preValid", 96'(bus.tvalid_data_o), 96'(1));
        checkOutput("rst.preMode", 96'(bus.mode_o), 96'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("rst.tvalid", 96'(bus.tvalid_data_o), 96'(0));
        checkOutput("rst.data", {bus.mode_o, bus.x_o, bus.y_o, bus.z_o}, 96'(0));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        sawValid = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.tvalid_data_o === 1'b1) sawValid = 1'b1;
        end
        checkOutput("rst.noStale", 96'(sawValid), 96'(0));
        checkOutput("rst.tready", 96'(bus.tready_data_i), 96'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
